// File: rtl/stopwatch_lap_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_lap_core
// Brief    : N-digit mixed-radix stopwatch with run/pause/clear and lap-hold
//            display. Optional macro STOPWATCH_OVF_HALT_EN: saturate and
//            pause at all-max instead of wrapping to zero.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_lap_core #(
    parameter int          NDIG      = 5,
    parameter int          TICK_DIV  = 10_000_000,
    parameter logic [7:0]  MOD6_MASK = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_lap,
    output logic [NDIG*4-1:0] disp_digits,
    output logic              running,
    output logic              lap_hold,
    output logic              overflow
);

    localparam int                 c_div_w   = $clog2(TICK_DIV);
    localparam logic [c_div_w-1:0] c_div_max = c_div_w'(TICK_DIV - 1);
`ifdef STOPWATCH_OVF_HALT_EN
    localparam logic               c_halt_en = 1'b1;
`else
    localparam logic               c_halt_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_start_prev;
    logic                  r_lap_prev;
    logic [c_div_w-1:0]    r_div;
    logic [NDIG*4-1:0]     r_count;
    logic [NDIG*4-1:0]     r_snapshot;
    logic                  r_lap_hold;
    logic                  r_overflow;

    logic                  w_start_press;
    logic                  w_lap_press;
    logic                  w_tick;
    logic                  w_all_max;
    logic [NDIG-1:0]       w_at_max;
    logic [NDIG-1:0]       w_carry;
    logic [NDIG*4-1:0]     w_count_inc;
    logic                  w_div_clear;
    logic                  w_count_clear;
    logic                  w_lap_next;
    logic                  w_snap_load;

    assign w_start_press = btn_start & ~r_start_prev;
    assign w_lap_press   = btn_lap   & ~r_lap_prev;
    assign w_tick        = (r_state == S_RUN) && (r_div == c_div_max);
    assign w_all_max     = &w_at_max;
    assign w_carry[0]    = w_tick;

    // Each digit sees a carry-in computed directly from the lower digits, so
    // the whole chain settles in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            localparam logic [3:0] c_max = MOD6_MASK[gi] ? 4'd5 : 4'd9;
            logic [3:0] w_dig;
            assign w_dig        = r_count[4*gi +: 4];
            assign w_at_max[gi] = (w_dig == c_max);
            assign w_count_inc[4*gi +: 4] = !w_carry[gi] ? w_dig :
                                            (w_at_max[gi] ? 4'd0 : w_dig + 4'd1);
            if (gi < NDIG - 1) begin : g_carry
                assign w_carry[gi+1] = w_carry[gi] & w_at_max[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_div_clear   = 1'b0;
        w_count_clear = 1'b0;
        w_lap_next    = r_lap_hold;
        w_snap_load   = 1'b0;
        running       = (r_state == S_RUN);
        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    w_state_next = S_RUN;
                    w_div_clear  = 1'b1;
                end
            end
            S_RUN: begin
                if (c_halt_en && w_tick && w_all_max) begin
                    w_state_next = S_PAUSE;
                    w_lap_next   = 1'b0;
                end else if (w_start_press) begin
                    w_state_next = S_PAUSE;
                    w_lap_next   = 1'b0;
                end else if (w_lap_press) begin
                    w_lap_next   = ~r_lap_hold;
                    w_snap_load  = ~r_lap_hold;
                end
            end
            S_PAUSE: begin
                // A saturated count cannot be resumed; only a clear leaves.
                if (w_start_press && !(c_halt_en && w_all_max)) begin
                    w_state_next = S_RUN;
                end else if (w_lap_press) begin
                    w_state_next  = S_IDLE;
                    w_count_clear = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_prev <= 1'b0;
            r_lap_prev   <= 1'b0;
            r_div        <= '0;
            r_count      <= '0;
            r_snapshot   <= '0;
            r_lap_hold   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_start_prev <= btn_start;
            r_lap_prev   <= btn_lap;
            r_lap_hold   <= w_lap_next;
            r_overflow   <= w_tick & w_all_max;
            if (w_snap_load) begin
                r_snapshot <= r_count;
            end
            if (w_div_clear) begin
                r_div <= '0;
            end else if (r_state == S_RUN) begin
                r_div <= (r_div == c_div_max) ? '0 : r_div + 1'b1;
            end
            if (w_count_clear) begin
                r_count <= '0;
            end else if (w_tick && !(c_halt_en && w_all_max)) begin
                r_count <= w_count_inc;
            end
        end
    end

    assign disp_digits = r_lap_hold ? r_snapshot : r_count;
    assign lap_hold    = r_lap_hold;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_lap_core
// Brief    : Directed plus random stimulus checked against an elapsed-tick
//            reference model for stopwatch_lap_core (s.s.t, digit1 radix 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_core;

    localparam int         NDIG     = 3;
    localparam int         TICK_DIV = 4;
    localparam logic [7:0] MASK     = 8'b0000_0010;
    localparam int         MODULUS  = 600;

`ifdef STOPWATCH_OVF_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_start;
    logic        btn_lap;
    logic [11:0] disp_digits;
    logic        running;
    logic        lap_hold;
    logic        overflow;

    stopwatch_lap_core #(
        .NDIG      (NDIG),
        .TICK_DIV  (TICK_DIV),
        .MOD6_MASK (MASK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .disp_digits (disp_digits),
        .running     (running),
        .lap_hold    (lap_hold),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: mode 0 idle, 1 run, 2 pause; count kept as elapsed tick number.
    int m_mode, m_n, m_div, m_snap;
    bit m_lap, m_ovf, m_ps, m_pl;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 60), 4'((n / 10) % 6), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit bs, input bit bl, input bit rs);
        bit ps, pl, tick;
        int nmode, nn, ndiv, nsnap;
        bit nlap;
        if (rs) begin
            m_mode = 0; m_n = 0; m_div = 0; m_snap = 0;
            m_lap = 0; m_ovf = 0; m_ps = 0; m_pl = 0;
            return;
        end
        ps    = bs && !m_ps;
        pl    = bl && !m_pl;
        tick  = (m_mode == 1) && (m_div == TICK_DIV - 1);
        nmode = m_mode; nn = m_n; ndiv = m_div; nsnap = m_snap; nlap = m_lap;
        if (m_mode == 1) begin
            ndiv = (m_div + 1) % TICK_DIV;
            if (tick) nn = (HALT && m_n == MODULUS - 1) ? m_n : (m_n + 1) % MODULUS;
        end
        case (m_mode)
            0: if (ps) begin nmode = 1; ndiv = 0; end
            1: begin
                if (HALT && tick && m_n == MODULUS - 1) begin nmode = 2; nlap = 0; end
                else if (ps) begin nmode = 2; nlap = 0; end
                else if (pl) begin
                    nlap = !m_lap;
                    if (!m_lap) nsnap = m_n;
                end
            end
            default: begin
                if (ps && !(HALT && m_n == MODULUS - 1)) nmode = 1;
                else if (pl) begin nmode = 0; nn = 0; end
            end
        endcase
        m_ovf = tick && (m_n == MODULUS - 1);
        m_mode = nmode; m_n = nn; m_div = ndiv; m_snap = nsnap; m_lap = nlap;
        m_ps = bs; m_pl = bl;
    endtask

    task automatic check_all();
        chk("disp",     32'(disp_digits), 32'(to_bcd(m_lap ? m_snap : m_n)));
        chk("running",  32'(running),     32'(m_mode == 1));
        chk("lap_hold", 32'(lap_hold),    32'(m_lap));
        chk("overflow", 32'(overflow),    32'(m_ovf));
    endtask

    task automatic cycle(input bit bs, input bit bl, input bit rs);
        btn_start = bs;
        btn_lap   = bl;
        reset     = rs;
        @(posedge clk);
        model_step(bs, bl, rs);
        #1;
        check_all();
    endtask

    task automatic run_until(input int target, input int budget);
        int b = 0;
        while (m_n != target && b < budget) begin
            cycle(0, 0, 0);
            b++;
        end
        chk("run_until_budget", 32'(b < budget), 32'd1);
    endtask

    initial begin
        logic [11:0] held;
        bit rs_b, rl_b;
        int b;
        btn_start = 0; btn_lap = 0; reset = 1;

        cycle(0, 0, 1);
        cycle(0, 0, 1);
        chk("rst_disp", 32'(disp_digits), 32'h000);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_lap", 32'(lap_hold), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        cycle(1, 0, 0);
        chk("start_running", 32'(running), 32'd1);
        repeat (4) cycle(0, 0, 0);
        chk("first_tick", 32'(disp_digits), 32'h001);
        repeat (4) cycle(0, 0, 0);
        chk("second_tick", 32'(disp_digits), 32'h002);

        run_until(23, 200);
        cycle(0, 1, 0);
        chk("lap_on", 32'(lap_hold), 32'd1);
        chk("lap_snap", 32'(disp_digits), 32'h023);
        cycle(0, 0, 0);
        run_until(31, 200);
        chk("lap_frozen", 32'(disp_digits), 32'h023);
        cycle(0, 1, 0);
        chk("lap_off", 32'(lap_hold), 32'd0);
        chk("lap_live", 32'(disp_digits), 32'(to_bcd(m_n)));
        cycle(0, 0, 0);

        run_until(59, 200);
        run_until(60, 20);
        chk("radix6_carry", 32'(disp_digits), 32'h100);

        cycle(1, 1, 0);
        chk("both_pause", 32'(running), 32'd0);
        held = disp_digits;
        repeat (8) cycle(0, 0, 0);
        chk("pause_held", 32'(disp_digits), 32'(held));
        chk("pause_nonzero", 32'(held != 12'h000), 32'd1);
        cycle(0, 1, 0);
        chk("clear_disp", 32'(disp_digits), 32'h000);
        chk("clear_running", 32'(running), 32'd0);
        cycle(0, 0, 0);

        cycle(1, 0, 0);
        cycle(0, 0, 0);
        run_until(599, 3000);
        chk("at_max", 32'(disp_digits), 32'h959);
        b = 0;
        while (!m_ovf && b < 8) begin cycle(0, 0, 0); b++; end
        chk("ovf_pulse", 32'(overflow), 32'd1);
        if (HALT) begin
            chk("halt_disp", 32'(disp_digits), 32'h959);
            chk("halt_running", 32'(running), 32'd0);
            cycle(1, 0, 0);
            repeat (5) cycle(0, 0, 0);
            chk("halt_start_ignored", 32'(running), 32'd0);
            chk("halt_still_max", 32'(disp_digits), 32'h959);
        end else begin
            chk("wrap_disp", 32'(disp_digits), 32'h000);
            chk("wrap_running", 32'(running), 32'd1);
            cycle(0, 0, 0);
            chk("ovf_one_cycle", 32'(overflow), 32'd0);
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
        cycle(0, 1, 0);
        chk("back_idle", 32'(disp_digits), 32'h000);
        cycle(0, 0, 0);

        repeat (20) cycle(1, 0, 0);
        chk("held_start_run", 32'(running), 32'd1);
        cycle(0, 0, 0);

        rs_b = 0; rl_b = 0;
        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) rs_b = ~rs_b;
            if ($urandom_range(0, 5) == 0) rl_b = ~rl_b;
            cycle(rs_b, rl_b, $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
